regfile_mp_sb: RTL

- Parametrised successor to the 32x32 two-read/one-write register file used by the single-cycle MIPS datapath.
- Generalises data width, depth and read-port count.
- Adds byte-enable writes, an optional hardwired zero register and an optional write-to-read bypass.
- Adds a per-register pending (scoreboard) bit with a live pending counter, so the upcoming multicycle/pipelined core can detect RAW hazards.

---
 rtl/regfile_mp_sb.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with byte-enable writes, optional hardwired r0 and
// write-to-read bypass, plus a per-register pending scoreboard with a live count.
module regfile_mp_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_READ-1:0]              rd_busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/8-1:0]          wr_be,
  input  logic                             set_en,
  input  logic [ADDR_WIDTH-1:0]            set_addr,
  output logic [ADDR_WIDTH:0]              pend_count
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  if ((DATA_WIDTH % 8) != 0 || NUM_READ < 1 || NUM_READ > 4) begin : g_bad_params
    $error("regfile_mp_sb: DATA_WIDTH must be a multiple of 8 and NUM_READ in 1..4");
  end

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_ok, set_ok, inc, dec;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
  assign set_ok = set_en && !(ZERO_REG != 0 && set_addr == '0);

  always_comb begin
    wr_merged = regs_q[wr_addr];
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (wr_be[b]) wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned d = 0; d < DEPTH; d++) regs_q[d] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_merged;
    end
  end

  // Bypass is gated by reset so a write held across reset cannot leak to rd_data.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    if (reset) begin
      for (int unsigned i = 0; i < NUM_READ; i++) begin
        if (BYPASS != 0 && wr_ok && rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr)
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_merged;
        else
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        rd_busy[i] = pend_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  // Set is applied after clear so a new producer on the retiring address wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[wr_addr]  = 1'b0;
    if (set_ok) pend_d[set_addr] = 1'b1;
    inc = set_ok && !pend_q[set_addr];
    dec = wr_ok && pend_q[wr_addr] && !(set_ok && set_addr == wr_addr);
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + CNT_ONE;
    else if (dec && !inc) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_count = cnt_q;

endmodule
